// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package hilo_pkg;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative shift-add multiplier / restoring divider on unsigned magnitudes,
// with sign restoration applied combinationally for the FIX cycle.
module muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             zero_div
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   dividend;
    logic               div_mode;
    logic               neg_q;
    logic               neg_r;

    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     top;
    logic [WIDTH+1:0]   diff;
    logic               unused_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        sign_a = is_signed & a[WIDTH-1];
        sign_b = is_signed & b[WIDTH-1];
        mag_a  = sign_a ? -a : a;
        mag_b  = sign_b ? -b : b;
    end

    // Multiply: add multiplicand into the upper half when the low bit is set.
    assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

    // Divide: partial remainder shifted left by one, trial-subtract the divisor.
    // The remainder stays below the divisor, so diff[WIDTH] is always zero on success.
    assign top         = acc[2*WIDTH-1:WIDTH-1];
    assign diff        = {1'b0, top} - {2'b0, opnd};
    assign unused_diff = diff[WIDTH];

    // Latch operands on accept, then iterate one bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            opnd     <= '0;
            dividend <= '0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero_div <= 1'b0;
        end else if (load) begin
            div_mode <= is_div;
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
            dividend <= a;
            zero_div <= is_div && (b == '0);
            if (is_div) begin
                acc  <= {{WIDTH{1'b0}}, mag_a};
                opnd <= mag_b;
            end else begin
                acc  <= {{WIDTH{1'b0}}, mag_b};
                opnd <= mag_a;
            end
        end else if (step) begin
            if (div_mode) begin
                if (!diff[WIDTH+1])
                    acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                else
                    acc <= {top[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc <= {add_sum, acc[WIDTH-1:1]};
            end
        end
    end

    // Sign correction and divide-by-zero substitution presented to the FIX write.
    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (div_mode) begin
            if (zero_div) begin
                res_hi = dividend;
                res_lo = '1;
            end else begin
                res_hi = rem;
                res_lo = quo;
            end
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register with multi-cycle multiply/divide and busy/done handshake.
//   state | meaning
//   IDLE  | accepts mul/div (to RUN) or MTHI/MTLO (direct write)
//   RUN   | WIDTH iterations, one quotient/product bit per cycle
//   FIX   | sign correction, HI/LO written, done pulsed on exit
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             accept_md;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             zero_div;

    assign accept_md = (state == IDLE) && start && !op[2];

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .load      (accept_md),
        .step      (state == RUN),
        .is_div    (op[1]),
        .is_signed (op[0]),
        .a         (src_a),
        .b         (src_b),
        .res_hi    (res_hi),
        .res_lo    (res_lo),
        .zero_div  (zero_div)
    );

    // Sequencing FSM with down-counter; HI/LO only change on MT writes or FIX exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                                state <= RUN;
                                busy  <= 1'b1;
                                cnt   <= CW'(WIDTH);
                            end
                            OP_MTHI: hi_out <= src_a;
                            OP_MTLO: lo_out <= src_a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= FIX;
                end
                FIX: begin
                    hi_out      <= res_hi;
                    lo_out      <= res_lo;
                    done        <= 1'b1;
                    div_by_zero <= zero_div;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench: directed cases plus randomized ops against an arithmetic model.
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, done, div_by_zero;
    logic [31:0] hi_out, lo_out;

    logic        start8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi_out(hi_out), .lo_out(lo_out)
    );

    hilo_muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8),
        .src_a(a8), .src_b(b8), .busy(busy8), .done(done8),
        .div_by_zero(dbz8), .hi_out(hi8), .lo_out(lo8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {HI,LO} straight from the arithmetic definition of each op.
    function automatic logic [63:0] ref32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_MULTU: return {32'h0, a} * {32'h0, b};
            OP_MULT:  return 64'(sa * sb);
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue a mul/div, optionally inject MTHI then MULT mid-run, and check the result.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inject, input string tag);
        logic [63:0] exp;
        int n;
        logic held_bad;
        exp = ref32(o, a, b);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
        chk({tag, "_busy_e0"}, 64'(busy), 64'd1);
        chk({tag, "_done_e0"}, 64'(done), 64'd0);
        n = 0;
        held_bad = 1'b0;
        while (!done && n < 40) begin
            if (n == inject) begin
                start = 1'b1; op = OP_MTHI; src_a = 32'h1234;
            end else if (n == inject + 1) begin
                start = 1'b1; op = OP_MULT; src_a = 32'd9; src_b = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (!done && (hi_out !== m_hi || lo_out !== m_lo || busy !== 1'b1))
                held_bad = 1'b1;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 64'(n), 64'd33);
        chk({tag, "_hold"}, 64'(held_bad), 64'd0);
        chk({tag, "_hilo"}, {hi_out, lo_out}, exp);
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'((o[1] == 1'b1) && (b == 0)));
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    task automatic mt_write(input logic [2:0] o, input logic [31:0] a, input string tag);
        start = 1'b1; op = o; src_a = a; src_b = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        if (o == OP_MTHI) m_hi = a;
        if (o == OP_MTLO) m_lo = a;
        chk({tag, "_hilo"}, {hi_out, lo_out}, {m_hi, m_lo});
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        logic saw_done;
        reset = 1'b1; start = 1'b0; op = OP_NOP; src_a = '0; src_b = '0;
        start8 = 1'b0; op8 = OP_NOP; a8 = '0; b8 = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hilo", {hi_out, lo_out}, 64'h0);
        chk("rst_flags", {61'h0, busy, done, div_by_zero}, 64'h0);
        reset = 1'b0;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 100, "multu_max");
        @(posedge clk); #1;
        chk("multu_done_once", 64'(done), 64'd0);
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 100, "mult_neg");
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 100, "div_neg");
        run_op(OP_DIVU, 32'd100, 32'd0, 100, "divu_zero");
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 100, "div_ovf");
        run_op(OP_MULTU, 32'd5, 32'd6, 100, "b2b_multu");

        run_op(OP_MULTU, 32'h0001_0003, 32'h0002_0007, 12, "inject");
        mt_write(OP_MTLO, 32'h0000_ABCD, "mtlo");
        mt_write(OP_MTHI, 32'h5555_AAAA, "mthi");
        mt_write(OP_NOP, 32'h1111_1111, "nop");

        start = 1'b1; op = OP_MULTU; src_a = 32'd123; src_b = 32'd456;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hilo", {hi_out, lo_out}, 64'h0);
        m_hi = '0; m_lo = '0;
        saw_done = done;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("midrst_no_done", 64'(saw_done), 64'd0);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2, 3: run_op(3'($urandom_range(0, 3)), pick(), pick(), 100, "rand_md");
                4: mt_write($urandom_range(0, 1) ? OP_MTHI : OP_MTLO, $urandom, "rand_mt");
                default: mt_write(3'($urandom_range(6, 7)), $urandom, "rand_nop");
            endcase
        end

        start8 = 1'b1; op8 = OP_MULTU; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        chk("w8_busy_e0", 64'(busy8), 64'd1);
        n = 0;
        while (!done8 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w8_latency", 64'(n), 64'd9);
        chk("w8_hilo", {48'h0, hi8, lo8}, 64'h0000_0000_0000_FE01);
        chk("w8_dbz", 64'(dbz8), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
